// File: rtl/mem_lsu.sv
// MEM stage load/store unit: issues data memory accesses over a req/gnt/rvalid
// handshake, aligns store lanes, extends load data and stalls the pipe meanwhile.
module mem_lsu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [XLEN-1:0] inst_addr_i,
    input  logic [4:0]      rd_waddr_i,
    input  logic            reg_wen_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      funct3_i,
    input  logic            mem_rd_i,
    input  logic            mem_wr_i,
    output logic [XLEN-1:0] inst_addr_o,
    output logic [4:0]      rd_waddr_o,
    output logic            reg_wen_o,
    output logic [XLEN-1:0] rd_wdata_o,
    output logic            valid_o,
    output logic            stall_o,
    output logic            misalign_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [7:0]      dmem_wmask_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    // state | meaning
    // IDLE  | pass-through, accept a new memory op
    // REQ   | request held on dmem until granted
    // RESP  | load granted, waiting for read data
    // DONE  | one-cycle result from captured registers
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] cap_inst_addr;
    logic [XLEN-1:0] cap_addr;
    logic [XLEN-1:0] cap_sdata;
    logic [XLEN-1:0] load_data;
    logic [4:0]      cap_rd;
    logic            cap_wen;
    logic            cap_store;
    logic [2:0]      cap_funct3;

    logic            mem_op;
    logic            aligned;
    logic            legal;
    logic            access_ok;
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_ext;
    logic [7:0]      mask_base;

    assign mem_op = mem_rd_i | mem_wr_i;

    always_comb begin
        aligned = 1'b1;
        case (funct3_i[1:0])
            2'b01:   aligned = (alu_result_i[0] == 1'b0);
            2'b10:   aligned = (alu_result_i[1:0] == 2'b00);
            2'b11:   aligned = (alu_result_i[2:0] == 3'b000);
            default: aligned = 1'b1;
        endcase
    end

    assign legal     = mem_rd_i ? (funct3_i != 3'b111) : (funct3_i[2] == 1'b0);
    assign access_ok = aligned & legal;

    // Load data arrives as a full doubleword; bring the addressed lane down to bit 0.
    assign rdata_shifted = dmem_rdata_i >> {cap_addr[2:0], 3'b000};

    always_comb begin
        load_ext = rdata_shifted;
        case (cap_funct3)
            3'b000:  load_ext = {{56{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'b001:  load_ext = {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b010:  load_ext = {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            3'b100:  load_ext = {56'b0, rdata_shifted[7:0]};
            3'b101:  load_ext = {48'b0, rdata_shifted[15:0]};
            3'b110:  load_ext = {32'b0, rdata_shifted[31:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    always_comb begin
        mask_base = 8'h01;
        case (cap_funct3[1:0])
            2'b00:   mask_base = 8'h01;
            2'b01:   mask_base = 8'h03;
            2'b10:   mask_base = 8'h0F;
            default: mask_base = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cap_inst_addr <= '0;
            cap_addr      <= '0;
            cap_sdata     <= '0;
            load_data     <= '0;
            cap_rd        <= '0;
            cap_wen       <= 1'b0;
            cap_store     <= 1'b0;
            cap_funct3    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && mem_op && access_ok) begin
                        cap_inst_addr <= inst_addr_i;
                        cap_addr      <= alu_result_i;
                        cap_sdata     <= store_data_i;
                        cap_rd        <= rd_waddr_i;
                        cap_wen       <= reg_wen_i;
                        cap_store     <= mem_wr_i;
                        cap_funct3    <= funct3_i;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) state <= cap_store ? DONE : RESP;
                end
                RESP: begin
                    if (dmem_rvalid_i) begin
                        load_data <= load_ext;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        inst_addr_o  = '0;
        rd_waddr_o   = '0;
        reg_wen_o    = 1'b0;
        rd_wdata_o   = '0;
        valid_o      = 1'b0;
        stall_o      = 1'b0;
        misalign_o   = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        dmem_wmask_o = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (valid_i && !mem_op) begin
                        inst_addr_o = inst_addr_i;
                        rd_waddr_o  = rd_waddr_i;
                        reg_wen_o   = reg_wen_i;
                        rd_wdata_o  = alu_result_i;
                        valid_o     = 1'b1;
                    end else if (valid_i && !access_ok) begin
                        inst_addr_o = inst_addr_i;
                        rd_waddr_o  = rd_waddr_i;
                        rd_wdata_o  = alu_result_i;
                        valid_o     = 1'b1;
                        misalign_o  = 1'b1;
                    end else if (valid_i) begin
                        stall_o = 1'b1;
                    end
                end
                REQ: begin
                    stall_o      = 1'b1;
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = cap_store;
                    dmem_addr_o  = {cap_addr[XLEN-1:3], 3'b000};
                    dmem_wdata_o = cap_store ? (cap_sdata << {cap_addr[2:0], 3'b000}) : '0;
                    dmem_wmask_o = cap_store ? (mask_base << cap_addr[2:0]) : 8'h00;
                end
                RESP: stall_o = 1'b1;
                default: begin
                    inst_addr_o = cap_inst_addr;
                    rd_waddr_o  = cap_rd;
                    reg_wen_o   = cap_wen & ~cap_store;
                    rd_wdata_o  = cap_store ? '0 : load_data;
                    valid_o     = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, loads, stores, faults and reset abort.
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [63:0] inst_addr_i;
    logic [4:0]  rd_waddr_i;
    logic        reg_wen_i;
    logic [63:0] alu_result_i;
    logic [63:0] store_data_i;
    logic [2:0]  funct3_i;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [63:0] inst_addr_o;
    logic [4:0]  rd_waddr_o;
    logic        reg_wen_o;
    logic [63:0] rd_wdata_o;
    logic        valid_o;
    logic        stall_o;
    logic        misalign_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [63:0] dmem_wdata_o;
    logic [7:0]  dmem_wmask_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;

    int vectors;
    int miscompares;

    mem_lsu dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .inst_addr_i(inst_addr_i),
        .rd_waddr_i(rd_waddr_i), .reg_wen_i(reg_wen_i), .alu_result_i(alu_result_i),
        .store_data_i(store_data_i), .funct3_i(funct3_i), .mem_rd_i(mem_rd_i),
        .mem_wr_i(mem_wr_i), .inst_addr_o(inst_addr_o), .rd_waddr_o(rd_waddr_o),
        .reg_wen_o(reg_wen_o), .rd_wdata_o(rd_wdata_o), .valid_o(valid_o),
        .stall_o(stall_o), .misalign_o(misalign_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_wmask_o(dmem_wmask_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 0; inst_addr_i = '0; rd_waddr_i = '0; reg_wen_i = 0;
        alu_result_i = '0; store_data_i = '0; funct3_i = '0; mem_rd_i = 0; mem_wr_i = 0;
        dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = '0;
    endtask

    task automatic garbage_inputs();
        valid_i = 1; inst_addr_i = 64'hDEAD; rd_waddr_i = 5'd31; reg_wen_i = 1;
        alu_result_i = 64'hFFFF_0007; store_data_i = 64'hFFFF_FFFF; funct3_i = 3'b011;
        mem_rd_i = 0; mem_wr_i = 1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [63:0] addr, input logic rd,
                         input logic wr, input logic [63:0] sdata);
        valid_i = 1; inst_addr_i = 64'h0000_0000_0000_0400; rd_waddr_i = 5'd9; reg_wen_i = 1;
        alu_result_i = addr; store_data_i = sdata; funct3_i = f3; mem_rd_i = rd; mem_wr_i = wr;
    endtask

    function automatic logic [255:0] all_outputs();
        return {inst_addr_o, rd_waddr_o, reg_wen_o, rd_wdata_o, valid_o, stall_o, misalign_o,
                dmem_req_o, dmem_we_o, dmem_addr_o[15:0], dmem_wdata_o[31:0], dmem_wmask_o,
                dmem_addr_o[63:16], dmem_wdata_o[63:32]};
    endfunction

    task automatic test_reset();
        rst = 1;
        issue(3'b000, 64'h10, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        vectors++;
        if (all_outputs() !== '0) begin
            miscompares++;
            $display("FAIL reset_alu outputs got %h want 0", all_outputs());
        end
        issue(3'b011, 64'h20, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        vectors++;
        if (all_outputs() !== '0) begin
            miscompares++;
            $display("FAIL reset_load outputs got %h want 0", all_outputs());
        end
        next_cycle();
        rst = 0;
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (all_outputs() !== '0) begin
            miscompares++;
            $display("FAIL idle_no_valid outputs got %h want 0", all_outputs());
        end
        next_cycle();
    endtask

    task automatic test_alu();
        idle_inputs();
        valid_i = 1; inst_addr_i = 64'h88; alu_result_i = 64'h1234; rd_waddr_i = 5'd5; reg_wen_i = 1;
        @(negedge clk);
        vectors++;
        if ({rd_wdata_o, rd_waddr_o, reg_wen_o, valid_o, stall_o, dmem_req_o, inst_addr_o} !==
            {64'h1234, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 64'h88}) begin
            miscompares++;
            $display("FAIL alu_pass wdata=%h rd=%0d wen=%b v=%b st=%b req=%b pc=%h",
                     rd_wdata_o, rd_waddr_o, reg_wen_o, valid_o, stall_o, dmem_req_o, inst_addr_o);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] rdata, input logic [63:0] expect_data);
        idle_inputs();
        issue(f3, addr, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        vectors++;
        if ({stall_o, dmem_req_o, valid_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL %s idle st/req/v got %b want 100", name, {stall_o, dmem_req_o, valid_o});
        end
        next_cycle();
        garbage_inputs();
        dmem_gnt_i = 1;
        @(negedge clk);
        vectors++;
        if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o} !== {3'b110, addr[63:3], 3'b000}) begin
            miscompares++;
            $display("FAIL %s req st/req/we=%b addr=%h want 110 %h", name,
                     {stall_o, dmem_req_o, dmem_we_o}, dmem_addr_o, {addr[63:3], 3'b000});
        end
        next_cycle();
        dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = rdata;
        @(negedge clk);
        vectors++;
        if ({stall_o, dmem_req_o, valid_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL %s resp st/req/v got %b want 100", name, {stall_o, dmem_req_o, valid_o});
        end
        next_cycle();
        dmem_rvalid_i = 0; dmem_rdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
        @(negedge clk);
        vectors++;
        if ({rd_wdata_o, valid_o, stall_o, reg_wen_o, rd_waddr_o, inst_addr_o} !==
            {expect_data, 1'b1, 1'b0, 1'b1, 5'd9, 64'h400}) begin
            miscompares++;
            $display("FAIL %s done data=%h v=%b st=%b wen=%b rd=%0d pc=%h want data=%h", name,
                     rd_wdata_o, valid_o, stall_o, reg_wen_o, rd_waddr_o, inst_addr_o, expect_data);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if ({valid_o, stall_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s back_to_idle v/st got %b want 00", name, {valid_o, stall_o});
        end
        next_cycle();
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] sdata, input int gnt_cycle,
                              input logic [63:0] expect_wdata, input logic [7:0] expect_mask);
        idle_inputs();
        issue(f3, addr, 1'b0, 1'b1, sdata);
        @(negedge clk);
        vectors++;
        if ({stall_o, dmem_req_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL %s idle st/req got %b want 10", name, {stall_o, dmem_req_o});
        end
        next_cycle();
        garbage_inputs();
        for (int i = 0; i <= gnt_cycle; i++) begin
            dmem_gnt_i = (i == gnt_cycle);
            @(negedge clk);
            vectors++;
            if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wmask_o} !==
                {3'b111, addr[63:3], 3'b000, expect_wdata, expect_mask}) begin
                miscompares++;
                $display("FAIL %s req%0d st/req/we=%b addr=%h wdata=%h mask=%h want wdata=%h mask=%h",
                         name, i, {stall_o, dmem_req_o, dmem_we_o}, dmem_addr_o, dmem_wdata_o,
                         dmem_wmask_o, expect_wdata, expect_mask);
            end
            next_cycle();
        end
        dmem_gnt_i = 0;
        @(negedge clk);
        vectors++;
        if ({valid_o, stall_o, reg_wen_o, dmem_req_o} !== 4'b1000) begin
            miscompares++;
            $display("FAIL %s done v/st/wen/req got %b want 1000", name,
                     {valid_o, stall_o, reg_wen_o, dmem_req_o});
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_fault(input string name, input logic [2:0] f3, input logic [63:0] addr,
                              input logic rd, input logic wr);
        idle_inputs();
        issue(f3, addr, rd, wr, 64'h77);
        @(negedge clk);
        vectors++;
        if ({misalign_o, valid_o, reg_wen_o, stall_o, dmem_req_o} !== 5'b11000) begin
            miscompares++;
            $display("FAIL %s mis/v/wen/st/req got %b want 11000", name,
                     {misalign_o, valid_o, reg_wen_o, stall_o, dmem_req_o});
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if ({misalign_o, valid_o, stall_o, dmem_req_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s after mis/v/st/req got %b want 0000", name,
                     {misalign_o, valid_o, stall_o, dmem_req_o});
        end
        next_cycle();
    endtask

    task automatic test_reset_abort();
        idle_inputs();
        issue(3'b011, 64'hA000, 1'b1, 1'b0, 64'h0);
        next_cycle();
        idle_inputs();
        dmem_gnt_i = 1;
        next_cycle();
        dmem_gnt_i = 0;
        rst = 1;
        @(negedge clk);
        vectors++;
        if (all_outputs() !== '0) begin
            miscompares++;
            $display("FAIL abort_in_resp outputs got %h want 0", all_outputs());
        end
        next_cycle();
        rst = 0;
        dmem_rvalid_i = 1; dmem_rdata_i = 64'hCAFE;
        @(negedge clk);
        vectors++;
        if (all_outputs() !== '0) begin
            miscompares++;
            $display("FAIL abort_late_rvalid outputs got %h want 0", all_outputs());
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if ({valid_o, stall_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_no_done v/st got %b want 00", {valid_o, stall_o});
        end
        next_cycle();
        valid_i = 1; alu_result_i = 64'h4242; rd_waddr_i = 5'd3; reg_wen_i = 1;
        @(negedge clk);
        vectors++;
        if ({rd_wdata_o, rd_waddr_o, valid_o, stall_o} !== {64'h4242, 5'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_then_alu wdata=%h rd=%0d v=%b st=%b", rd_wdata_o, rd_waddr_o,
                     valid_o, stall_o);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        idle_inputs();
        rst = 1;
        test_reset();
        test_alu();
        test_load("lb",  3'b000, 64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        test_load("lwu", 3'b110, 64'h2004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
        test_load("lh",  3'b001, 64'h5006, 64'hF00D_0000_0000_0000, 64'hFFFF_FFFF_FFFF_F00D);
        test_load("lhu", 3'b101, 64'h5006, 64'hF00D_0000_0000_0000, 64'h0000_0000_0000_F00D);
        test_load("lw",  3'b010, 64'h5000, 64'h0000_0000_9000_0001, 64'hFFFF_FFFF_9000_0001);
        test_load("lbu", 3'b100, 64'h5007, 64'hC300_0000_0000_0000, 64'h0000_0000_0000_00C3);
        test_load("ld",  3'b011, 64'h6008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        test_store("sh", 3'b001, 64'h3006, 64'hABCD, 2, 64'hABCD_0000_0000_0000, 8'hC0);
        test_store("sb", 3'b000, 64'h7001, 64'h55, 0, 64'h5500, 8'h02);
        test_store("sw", 3'b010, 64'h900C, 64'hDEAD_BEEF, 1, 64'hDEAD_BEEF_0000_0000, 8'hF0);
        test_store("sd", 3'b011, 64'h8000, 64'h1122_3344_5566_7788, 0, 64'h1122_3344_5566_7788, 8'hFF);
        test_fault("lw_misaligned", 3'b010, 64'h4002, 1'b1, 1'b0);
        test_fault("ld_misaligned", 3'b011, 64'h4004, 1'b1, 1'b0);
        test_fault("sh_misaligned", 3'b001, 64'h4001, 1'b0, 1'b1);
        test_fault("load_f3_111",   3'b111, 64'h4000, 1'b1, 1'b0);
        test_fault("store_f3_100",  3'b100, 64'h4000, 1'b0, 1'b1);
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
